apb_master_bridge: RTL and testbench

//  APB requester (initiator) that turns a simple valid/ready command stream into APB transfers.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master_bridge.sv | 116 +++++++++++
 tb/tb_apb_master_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester definitions: one-hot FSM encodings and transfer direction codes.
package apb_pkg;

    typedef logic [3:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 4'b0001;
    localparam apb_state_t ST_SETUP  = 4'b0010;
    localparam apb_state_t ST_ACCESS = 4'b0100;
    localparam apb_state_t ST_RESP   = 4'b1000;

    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_READ  = 1'b0;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase; flags the cycle on which the count reaches LIMIT.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    if (LIMIT == 0) begin : g_off
        assign expire = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(LIMIT + 1);

        logic [CW-1:0] count_q;

        always_ff @(posedge pclk) begin
            if (!prst || clear) begin
                count_q <= '0;
            end else if (enable) begin
                count_q <= count_q + 1'b1;
            end
        end

        // Asserted in the cycle whose increment would make the count equal LIMIT.
        assign expire = enable && (count_q == CW'(LIMIT - 1));
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: converts a valid/ready command stream into single APB transfers with
// an optional wait-state timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwr_rd_en,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perror
);

    apb_state_t state_q;
    logic       wait_expire;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk   (pclk),
        .prst   (prst),
        .clear  (state_q != ST_ACCESS),
        .enable ((state_q == ST_ACCESS) && !pready),
        .expire (wait_expire)
    );

    // paddr/pwr_rd_en/pwdata double as the command holding register for the whole transfer.
    always_ff @(posedge pclk) begin
        if (!prst) begin
            state_q     <= ST_IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwr_rd_en   <= APB_READ;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwr_rd_en <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= (cmd_write == APB_WRITE) ? cmd_wdata : '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over a timeout landing on the same cycle.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_error   <= perror;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (pwr_rd_en == APB_WRITE) ? '0 : prdata;
                        state_q     <= ST_RESP;
                    end else if (wait_expire) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench drives the APB responder side itself.
module tb_apb_master_bridge;

    logic       pclk;
    logic       prst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic       rsp_error;
    logic       rsp_timeout;
    logic       psel;
    logic       penable;
    logic       pwr_rd_en;
    logic [3:0] paddr;
    logic [3:0] pwdata;
    logic [3:0] prdata;
    logic       pready;
    logic       perror;

    int checks;
    int failures;

    apb_master_bridge #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .prst        (prst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwr_rd_en   (pwr_rd_en),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .perror      (perror)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        prst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 4'h0;
        rsp_ready = 1'b0;
        prdata    = 4'h0;
        pready    = 1'b0;
        perror    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        prst = 1'b1;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);

        // 1: write addr=3 data=9; pready held high throughout (no effect outside ACCESS)
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 4'h9; pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_penable", penable, 0);
        chk("t1_paddr", paddr, 3);
        chk("t1_pwdata", pwdata, 9);
        chk("t1_dir", pwr_rd_en, 1);
        chk("t1_cmd_ready", cmd_ready, 0);
        tick();
        chk("t1_access_psel", psel, 1);
        chk("t1_access_penable", penable, 1);
        chk("t1_access_rsp_valid", rsp_valid, 0);
        tick();
        chk("t1_end_psel", psel, 0);
        chk("t1_end_penable", penable, 0);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_error", rsp_error, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1; pready = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("t1_rsp_taken", rsp_valid, 0);
        chk("t1_cmd_ready_back", cmd_ready, 1);

        // 2: read addr=5 with 3 wait states, prdata=A on completion
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5; cmd_wdata = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("t2_pwdata_read", pwdata, 0);
        chk("t2_dir", pwr_rd_en, 0);
        tick();
        prdata = 4'h7;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_penable", penable, 1);
            chk("t2_wait_paddr", paddr, 5);
            chk("t2_wait_dir", pwr_rd_en, 0);
            tick();
        end
        pready = 1'b1; prdata = 4'hA;
        chk("t2_last_paddr", paddr, 5);
        tick();
        pready = 1'b0; prdata = 4'h0;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_rdata", rsp_rdata, 4'hA);
        chk("t2_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: read, pready never comes -> timeout after 16 ACCESS cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        tick();
        cmd_valid = 1'b0; prdata = 4'hF;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("t3_wait_penable", penable, 1);
            tick();
        end
        chk("t3_psel", psel, 0);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_timeout", rsp_timeout, 1);
        chk("t3_rsp_error", rsp_error, 1);
        chk("t3_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t3_timeout_clear", rsp_timeout, 0);

        // 3b: pready on the 16th ACCESS cycle wins over the timeout
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h6;
        tick();
        cmd_valid = 1'b0; prdata = 4'h0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t3b_still_access", penable, 1);
        pready = 1'b1; prdata = 4'hC;
        tick();
        pready = 1'b0; prdata = 4'h0;
        chk("t3b_rsp_valid", rsp_valid, 1);
        chk("t3b_rsp_timeout", rsp_timeout, 0);
        chk("t3b_rsp_error", rsp_error, 0);
        chk("t3b_rsp_rdata", rsp_rdata, 4'hC);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 4: write with perror (perror alone, without pready, is ignored)
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 4'h6; perror = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t4_perror_no_pready", rsp_valid, 0);
        pready = 1'b1;
        tick();
        pready = 1'b0; perror = 1'b0;
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_error", rsp_error, 1);
        chk("t4_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 5: cmd_valid held, response stalled 5 cycles -> no early second transfer
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h7; cmd_wdata = 4'h3; pready = 1'b1;
        tick();
        chk("t5_c1_paddr", paddr, 7);
        tick();
        tick();
        cmd_addr = 4'h8; cmd_wdata = 4'h4;
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_cmd_ready", cmd_ready, 0);
            chk("t5_stall_psel", psel, 0);
            chk("t5_stall_rsp_valid", rsp_valid, 1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_idle_cmd_ready", cmd_ready, 1);
        chk("t5_idle_psel", psel, 0);
        tick();
        chk("t5_c2_psel", psel, 1);
        chk("t5_c2_paddr", paddr, 8);
        chk("t5_c2_pwdata", pwdata, 4);
        cmd_addr = 4'h9;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t5_c2_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1; pready = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("t5_c3_not_taken", psel, 0);

        // 6: reset during ACCESS aborts the transfer
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t6_in_access", penable, 1);
        prst = 1'b0;
        tick();
        chk("t6_psel", psel, 0);
        chk("t6_penable", penable, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_cmd_ready", cmd_ready, 0);
        chk("t6_paddr", paddr, 0);
        prst = 1'b1;
        tick();
        chk("t6_ready_after", cmd_ready, 1);
        chk("t6_no_rsp", rsp_valid, 0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 4'h5; pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t6_new_paddr", paddr, 4'hA);
        tick();
        tick();
        chk("t6_new_rsp_valid", rsp_valid, 1);
        chk("t6_new_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1; pready = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("t6_new_done", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
